// File: rtl/sel_pkg.sv
// Lane map, lane formats and the narrowing rule shared by the distributor
// and its testbench-facing top.
package sel_pkg;

    localparam int LANE_CNT = 4;
    localparam int DATA_W   = 5;
    localparam int MAX_W    = 4;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    typedef enum logic {UNSIGNED, SIGNED} lane_fmt_e;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] data;
    } lane_word_t;

    function automatic int lane_width(input int lane);
        return (lane == 0) ? 2 : 4;
    endfunction

    function automatic lane_fmt_e lane_fmt(input int lane);
        return (lane < 2) ? UNSIGNED : SIGNED;
    endfunction

    // Keeps the low w bits and flags any value outside the lane's range.
    function automatic lane_word_t narrow(input logic [DATA_W-1:0] v, input int w,
                                          input lane_fmt_e fmt);
        lane_word_t r;
        int         val;
        int         lo;
        int         hi;
        val = int'($signed(v));
        if (fmt == UNSIGNED) begin
            lo = 0;
            hi = (1 << w) - 1;
        end else begin
            lo = -(1 << (w - 1));
            hi = (1 << (w - 1)) - 1;
        end
        r.data = v[MAX_W-1:0] & MAX_W'((1 << w) - 1);
        r.ovf  = (val < lo) || (val > hi);
        return r;
    endfunction

endpackage

// File: rtl/sel_lane_reg.sv
// Single-entry valid/ready holding register; accepts a new beat on the same
// edge the held one drains.
module sel_lane_reg #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         ready,
    input  logic [W-1:0] din,
    output logic         free,
    output logic         valid,
    output logic [W-1:0] dout
);

    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sel_distributor.sv
// Routes a 5-bit signed stream to four narrower registered lanes; selector
// codes without a lane are swallowed and counted.
module sel_distributor
    import sel_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       out0_data,
    output logic [3:0]       out1_data,
    output logic [3:0]       out2_data,
    output logic [3:0]       out3_data,
    output logic             out0_ovf,
    output logic             out1_ovf,
    output logic             out2_ovf,
    output logic             out3_ovf,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic             out2_valid,
    output logic             out3_valid,
    input  logic             out0_ready,
    input  logic             out1_ready,
    input  logic             out2_ready,
    input  logic             out3_ready,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             drop_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [LANE_CNT-1:0]            lane_ready;
    logic [LANE_CNT-1:0]            lane_free;
    logic [LANE_CNT-1:0]            lane_valid;
    logic [LANE_CNT-1:0]            lane_ovf;
    logic [LANE_CNT-1:0]            load;
    logic [LANE_CNT-1:0][MAX_W-1:0] lane_data;
    logic                           has_lane;
    logic                           accept;

    assign lane_ready = {out3_ready, out2_ready, out1_ready, out0_ready};
    assign has_lane   = in_sel < SEL_W'(LANE_CNT);

    always_comb begin
        in_ready = 1'b0;
        if (rst_n)
            in_ready = has_lane ? lane_free[in_sel[1:0]] : 1'b1;
    end

    assign accept = in_valid && in_ready;

    for (genvar g = 0; g < LANE_CNT; g++) begin : g_lane
        localparam int W = lane_width(g);
        lane_word_t nw;
        logic [W:0] q;

        assign nw      = narrow(in_data, W, lane_fmt(g));
        assign load[g] = accept && has_lane && (in_sel[1:0] == 2'(g));

        sel_lane_reg #(.W(W + 1)) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[g]),
            .ready (lane_ready[g]),
            .din   ({nw.ovf, nw.data[W-1:0]}),
            .free  (lane_free[g]),
            .valid (lane_valid[g]),
            .dout  (q)
        );

        assign lane_data[g] = MAX_W'(q[W-1:0]);
        assign lane_ovf[g]  = q[W];

        // narrow() masks the bits above W, so they carry nothing here
        if (W < MAX_W) begin : g_pad
            logic unused_hi;
            assign unused_hi = ^nw.data[MAX_W-1:W];
        end
    end

    assign out0_data = lane_data[0][1:0];
    assign out1_data = lane_data[1];
    assign out2_data = lane_data[2];
    assign out3_data = lane_data[3];
    assign {out3_ovf, out2_ovf, out1_ovf, out0_ovf}         = lane_ovf;
    assign {out3_valid, out2_valid, out1_valid, out0_valid} = lane_valid;

    logic unused_pad;
    assign unused_pad = ^lane_data[0][MAX_W-1:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= accept && !has_lane;
            if (accept && !has_lane && drop_cnt != CNT_MAX)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sel_distributor.sv
// Directed and random stimulus for sel_distributor against an arithmetic
// model of the lanes and the drop counter.
module tb_sel_distributor;

    localparam int SEL_W = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       in_data;
    logic [SEL_W-1:0] in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       out0_data;
    logic [3:0]       out1_data, out2_data, out3_data;
    logic             out0_ovf, out1_ovf, out2_ovf, out3_ovf;
    logic             out0_valid, out1_valid, out2_valid, out3_valid;
    logic             out0_ready, out1_ready, out2_ready, out3_ready;
    logic [CNT_W-1:0] drop_cnt;
    logic             drop_pulse;

    int total = 0;
    int bad   = 0;

    int m_vld [4];
    int m_dat [4];
    int m_ovf [4];
    int m_cnt;
    int m_pulse;

    always #5 clk = ~clk;

    sel_distributor #(.SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out1_data  (out1_data),
        .out2_data  (out2_data),
        .out3_data  (out3_data),
        .out0_ovf   (out0_ovf),
        .out1_ovf   (out1_ovf),
        .out2_ovf   (out2_ovf),
        .out3_ovf   (out3_ovf),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .out2_valid (out2_valid),
        .out3_valid (out3_valid),
        .out0_ready (out0_ready),
        .out1_ready (out1_ready),
        .out2_ready (out2_ready),
        .out3_ready (out3_ready),
        .drop_cnt   (drop_cnt),
        .drop_pulse (drop_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int lw(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic int exp_dat(input int k, input int v);
        int m;
        m = 1 << lw(k);
        return ((v % m) + m) % m;
    endfunction

    function automatic int exp_ovf(input int k, input int v);
        int w;
        w = lw(k);
        if (k >= 2) return int'(v < -(1 << (w - 1)) || v > (1 << (w - 1)) - 1);
        return int'(v < 0 || v > (1 << w) - 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_vld[k] = 0;
            m_dat[k] = 0;
            m_ovf[k] = 0;
        end
        m_cnt   = 0;
        m_pulse = 0;
    endtask

    task automatic check_outs();
        logic [3:0] ov, of;
        logic [3:0] od [4];
        ov = {out3_valid, out2_valid, out1_valid, out0_valid};
        of = {out3_ovf, out2_ovf, out1_ovf, out0_ovf};
        od[0] = {2'b00, out0_data};
        od[1] = out1_data;
        od[2] = out2_data;
        od[3] = out3_data;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("out%0d_valid", k), 32'(ov[k]), m_vld[k]);
            chk($sformatf("out%0d_data", k), 32'(od[k]), m_dat[k]);
            chk($sformatf("out%0d_ovf", k), 32'(of[k]), m_ovf[k]);
        end
        chk("drop_cnt", 32'(drop_cnt), m_cnt);
        chk("drop_pulse", 32'(drop_pulse), m_pulse);
    endtask

    // One clock: drive, check in_ready, advance the model, check outputs.
    task automatic step(input int v, input int sel, input bit vld, input bit [3:0] rdy);
        int erdy;
        int acc;
        in_data  = 5'(v);
        in_sel   = SEL_W'(sel);
        in_valid = vld;
        {out3_ready, out2_ready, out1_ready, out0_ready} = rdy;
        #1;
        erdy = (sel >= 4) ? 1 : int'(m_vld[sel] == 0 || rdy[sel]);
        chk("in_ready", 32'(in_ready), erdy);
        acc = int'(vld) & erdy;
        for (int k = 0; k < 4; k++) begin
            if (acc != 0 && sel == k) begin
                m_vld[k] = 1;
                m_dat[k] = exp_dat(k, v);
                m_ovf[k] = exp_ovf(k, v);
            end else if (m_vld[k] != 0 && rdy[k]) begin
                m_vld[k] = 0;
            end
        end
        m_pulse = int'(acc != 0 && sel >= 4);
        if (m_pulse != 0 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        @(posedge clk);
        #1;
        check_outs();
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_sel     = '0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        out3_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("in_ready_in_reset", 32'(in_ready), 0);
        check_outs();
        rst_n = 1'b1;

        // first beat to lane 0
        step(3, 0, 1, 4'b0001);
        chk("lane0_first_data", 32'(out0_data), 3);
        step(0, 0, 0, 4'b0001);

        // -5 into a signed and an unsigned 4-bit lane
        step(-5, 2, 1, 4'b0000);
        chk("lane2_neg5", {27'd0, out2_ovf, out2_data}, {27'd0, 1'b0, 4'b1011});
        step(-5, 1, 1, 4'b0000);
        chk("lane1_neg5", {27'd0, out1_ovf, out1_data}, {27'd0, 1'b1, 4'b1011});
        step(0, 0, 0, 4'b1111);

        // backpressure on lane 3, then drain and reload on one edge
        step(6, 3, 1, 4'b0000);
        step(-7, 3, 1, 4'b0000);
        chk("lane3_stalled_data", 32'(out3_data), 6);
        step(-7, 3, 1, 4'b1000);
        chk("lane3_reload_data", 32'(out3_data), 4'b1001);
        step(0, 0, 0, 4'b1000);

        // none codes with all lanes stalled
        step(1, 4, 1, 4'b0000);
        step(2, 4, 1, 4'b0000);
        step(3, 0, 1, 4'b0000);
        step(4, 0, 1, 4'b0000);
        step(2, 5, 1, 4'b0000);
        step(9, 5, 1, 4'b0000);
        step(-1, 7, 1, 4'b0000);
        step(0, 0, 0, 4'b1111);

        // lane 0 streaming
        for (int i = 0; i < 8; i++) step(i - 2, 0, 1, 4'b0001);
        step(0, 0, 0, 4'b1111);

        // random traffic
        for (int i = 0; i < 300; i++)
            step(int'($urandom_range(31)) - 16, int'($urandom_range(7)),
                 1'($urandom_range(1)), 4'($urandom_range(15)));

        // drive the counter into saturation
        for (int i = 0; i < 260; i++) step(i % 32 - 16, 4 + i % 4, 1, 4'b0000);
        chk("drop_cnt_saturated", 32'(drop_cnt), (1 << CNT_W) - 1);

        // reset while lanes 1 and 2 hold beats
        step(7, 1, 1, 4'b0000);
        step(-8, 2, 1, 4'b0000);
        rst_n    = 1'b0;
        in_sel   = SEL_W'(5);
        in_valid = 1'b1;
        #1;
        chk("in_ready_mid_reset", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        model_reset();
        check_outs();
        rst_n = 1'b1;
        step(0, 0, 0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
